// File: rtl/imem_if.sv
// Instruction-memory request/acknowledge bundle between the fetch unit (master)
// and instruction memory (slave).
interface imem_if #(
  parameter int PC_WIDTH = 10
);
  logic                imem_req;
  logic [PC_WIDTH-3:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time over a req/ack handshake
// into a single-entry instruction register, and handles execute redirects.
module instr_fetch_unit #(
  parameter int PC_WIDTH = 10,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_if.master              imem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                misalign_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-3:0] kill_addr;

  logic consume;
  logic can_accept;
  logic do_redirect;
  logic do_load;
  logic kill_capture;

  assign consume    = instr_valid && !stall;
  assign can_accept = !instr_valid || !stall;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    do_redirect    = 1'b0;
    do_load        = 1'b0;
    kill_capture   = 1'b0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc[PC_WIDTH-1:2];

    case (state)
      IDLE: begin
        if (redirect_valid) begin
          do_redirect = 1'b1;
        end else if (can_accept) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        imem.imem_req = 1'b1;
        if (redirect_valid) begin
          // A redirect always wins; an unacknowledged request must still be
          // drained so the handshake is never abandoned.
          do_redirect  = 1'b1;
          kill_capture = !imem.imem_ack;
          state_next   = imem.imem_ack ? IDLE : KILL;
        end else if (imem.imem_ack) begin
          do_load    = 1'b1;
          state_next = IDLE;
        end
      end
      KILL: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = kill_addr;
        if (redirect_valid) do_redirect = 1'b1;
        if (imem.imem_ack)  state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= PC_WIDTH'(RESET_PC);
      kill_addr      <= '0;
      instr_valid    <= 1'b0;
      instruction    <= '0;
      instr_pc       <= '0;
      misalign_fault <= 1'b0;
    end else begin
      misalign_fault <= do_redirect && (redirect_pc[1:0] != 2'b00);

      if (kill_capture) kill_addr <= pc[PC_WIDTH-1:2];

      // Redirect flushes the IR and takes priority over consume; a load in the
      // same edge as a consume leaves the new word valid.
      if (do_redirect) begin
        pc          <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
        instr_valid <= 1'b0;
      end else if (do_load) begin
        instruction <= imem.imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_WIDTH'(4);
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder. Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Holds the returned word in a single-entry instruction register whose `instruction` output drives the decoder's instruction input.
- Accepts redirects (jump/taken branch) from execute, kills the in-flight fetch and flags misaligned targets.

Parameters:
- PC_WIDTH, 10: byte-address width of the PC.
- RESET_PC, 0: PC value loaded on reset (must be a multiple of 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  PC_WIDTH-2  word address of the request.
- imem_ack  in  1  single-cycle acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  downstream busy; IR not consumed while high.
- redirect_valid  in  1  one-cycle pulse: jump or taken branch.
- redirect_pc  in  PC_WIDTH  redirect target byte address.
- instr_valid  out  1  IR holds a valid instruction.
- instruction  out  32  IR contents, to the decoder.
- instr_pc  out  PC_WIDTH  byte address of `instruction`.
- misalign_fault  out  1  one-cycle pulse when the accepted redirect_pc[1:0] != 0.

Behaviour:
Reset:
- Asynchronous on rst_n low: state=IDLE, pc=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, misalign_fault=0, kill_addr=0.
- imem_req drops immediately, since it is decoded from state.

Definitions:
- consume = instr_valid && !stall. The decoder takes IR on that edge.
- can_accept = !instr_valid || !stall.

States:
- IDLE: imem_req=0.
  - redirect_valid -> apply redirect, stay IDLE.
  - else can_accept -> FETCH.
  - else stay IDLE.
- FETCH: imem_req=1, imem_addr=pc[PC_WIDTH-1:2].
  - redirect_valid && imem_ack -> discard rdata, apply redirect, go to IDLE.
  - redirect_valid && !imem_ack -> kill_addr<=pc[PC_WIDTH-1:2], apply redirect, go to KILL.
  - imem_ack alone -> instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps modulo 2^PC_WIDTH), go to IDLE.
  - otherwise stay FETCH; imem_addr stays stable.
- KILL: imem_req=1, imem_addr=kill_addr.
  - imem_ack -> discard rdata, go to IDLE.
  - redirect_valid -> apply redirect (pc updates, kill_addr unchanged).
  - redirect_valid and imem_ack together -> both actions, go to IDLE.

Apply redirect:
- pc<=redirect_pc with bits [1:0] forced to 0.
- instr_valid<=0 (flush). Redirect beats consume; a flushed IR is never consumed.
- misalign_fault<=1 for exactly one cycle if redirect_pc[1:0]!=0.

Invariants:
- At most one outstanding request.
- FETCH is entered only when can_accept, so IR is empty (or emptied by consume) whenever imem_ack delivers data.
- A consume and an IR load in the same edge is legal: the new word wins.
- imem_ack in IDLE is ignored.
- imem_req never deasserts before imem_ack except on reset.

Timing:
- Zero-wait memory (ack in the first FETCH cycle) with stall=0 sustains one instruction every 2 cycles.
- Latency: imem_ack at edge t gives instr_valid=1 after edge t.
- Reset mid-request abandons the request; memory is reset by the same rst_n.

Test Plan:
- Reset release, zero-wait memory, stall=0 -> imem_addr sequence 0,1,2,3; instr_pc 0x000,0x004,0x008,0x00C; instruction equals imem_rdata; instr_valid high 1 of every 2 cycles.
- stall held high 5 cycles with instr_valid=1 -> imem_req stays 0, instruction/instr_pc unchanged; stall falls -> next fetch uses pc+4.
- Memory with 3-cycle ack latency, redirect_valid pulse (redirect_pc=0x100) one cycle after imem_req rises -> imem_addr holds the old address until ack, that rdata is never presented, next imem_addr=0x40, instr_pc=0x100.
- Redirect coinciding with imem_ack in FETCH -> rdata discarded, instr_valid=0, next request addr=redirect_pc>>2.
- redirect_pc=0x102 -> misalign_fault high exactly 1 cycle, next fetch instr_pc=0x100.
- rst_n asserted mid-FETCH -> imem_req low in the same cycle, outputs at reset values; pc=0x3FC with no redirect -> next pc wraps to 0x000.
